multiplier_arbiter: RTL and testbench
=====================================

MULTIPLIER_ARBITER -- requirements
Module: multiplier_arbiter

Interface
REQ-001 Parameter DATA_WIDTH_1, default 8: width of operand 1, unsigned.
REQ-002 Parameter DATA_WIDTH_2, default 8: width of operand 2, unsigned.
REQ-003 Parameter NUM_REQ, default 4: number of requesters; legal range 2..16.
REQ-004 Parameter MULT_LATENCY, default 1: register stages inside the shared multiplier core.
REQ-005 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 req_valid_i  in  NUM_REQ  requester i has an operand pair pending (bit i).
REQ-008 req_ready_o  out  NUM_REQ  requester i is granted this cycle (bit i).
REQ-009 req_data1_i  in  NUM_REQ*DATA_WIDTH_1  packed operand 1; requester i occupies slice [i*DATA_WIDTH_1 +: DATA_WIDTH_1].
REQ-010 req_data2_i  in  NUM_REQ*DATA_WIDTH_2  packed operand 2; same packing rule.
REQ-011 res_valid_o  out  NUM_REQ  one-hot one-cycle strobe: result belongs to requester i.
REQ-012 res_data_o  out  DATA_WIDTH_1+DATA_WIDTH_2  product of the strobed requester's operands.

Function
REQ-013 Handshake: transfer for requester i SHALL occur on the rising edge where req_valid_i[i] and req_ready_o[i] are both high.
REQ-014 req_ready_o SHALL be combinational from req_valid_i and the round-robin pointer, at most one bit high, and never high for a non-valid requester.
REQ-015 Requesters SHALL NOT make valid depend on ready; a requester SHALL hold valid and operands stable until its transfer.
REQ-016 Arbitration: scan from pointer upward (mod NUM_REQ); first valid requester is granted.
REQ-017 On a grant to k, pointer SHALL become (k+1) mod NUM_REQ; with no grant, pointer SHALL hold.
REQ-018 Wrap-around: grant to NUM_REQ-1 SHALL set pointer to 0.
REQ-019 At most one transfer per cycle; sustained throughput SHALL be one product per clock with no bubbles.
REQ-020 On transfer, operands SHALL be registered into the multiplier inputs, and tag k SHALL enter a valid/tag shift pipeline of depth MULT_LATENCY+1.
REQ-021 Latency: for a transfer at edge n, res_valid_o[k] and res_data_o SHALL be valid for exactly the cycle after edge n+MULT_LATENCY+1 (2 edges after transfer by default).
REQ-022 Results SHALL emerge in grant order; there is no result backpressure, and consumers SHALL accept every strobe.
REQ-023 Multiplication SHALL be unsigned and full-width; no truncation or overflow is possible.
REQ-024 When res_valid_o is all-zero, res_data_o is don't-care; benches SHALL NOT check it.
REQ-025 A newly valid requester SHALL wait at most NUM_REQ-1 grants to other requesters before its own grant (starvation-free).

Reset
REQ-026 While rst is high, req_ready_o SHALL be 0, res_valid_o SHALL be 0, pointer SHALL be 0, and the valid/tag pipeline SHALL be cleared.
REQ-027 Reset mid-operation SHALL discard all in-flight products; no res_valid_o strobe SHALL appear for pre-reset transfers.
REQ-028 First grant is possible in the first cycle after rst deasserts, starting from requester 0.

Structure
REQ-029 A shared constants package/include SHALL hold default widths and TAG_WIDTH = clog2(NUM_REQ).
REQ-030 The existing multiplier module SHALL be instantiated as the single sub-module; arbitration, operand muxing and the tag pipeline live in multiplier_arbiter.
REQ-031 Target size: 120-400 lines of RTL.

Verification
REQ-032 Single requester 0, operands 34,22 → res_valid_o=0001 with res_data_o=748, two edges after transfer.
REQ-033 Requester 2 streams (34,9),(9,9),(99,99) back-to-back → ready held high; results 306, 81, 9801 on three consecutive cycles.
REQ-034 All four valid at once after reset → grants in order 0,1,2,3; result strobes in the same order, one per cycle.
REQ-035 Requesters 1 and 3 continuously valid with pointer at 2 → grants alternate 3,1,3,1; requester 0 turns valid → granted within 3 grants.
REQ-036 Transfer of 255,255 then rst high on the next edge → no strobe for the 65025 product; all outputs 0 during reset.
REQ-037 Idle (no valid) for 10 cycles → req_ready_o=0, res_valid_o=0, pointer unchanged.

Source files
------------

// File: rtl/multiplier_arbiter_pkg.sv
// multiplier_arbiter_pkg: shared defaults and tag sizing for the round-robin multiplier arbiter
package multiplier_arbiter_pkg;

    localparam int DEF_DATA_WIDTH_1 = 8;
    localparam int DEF_DATA_WIDTH_2 = 8;
    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_MULT_LATENCY = 1;

    function automatic int tag_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_TAG_WIDTH = tag_width(DEF_NUM_REQ);

endpackage

// File: rtl/multiplier_arbiter_mult.sv
// multiplier_arbiter_mult: unsigned full-width multiplier with LATENCY register stages
module multiplier_arbiter_mult
    import multiplier_arbiter_pkg::*;
#(
    parameter int WA      = DEF_DATA_WIDTH_1,
    parameter int WB      = DEF_DATA_WIDTH_2,
    parameter int LATENCY = DEF_MULT_LATENCY
) (
    input  logic             clk,
    input  logic [WA-1:0]    a,
    input  logic [WB-1:0]    b,
    output logic [WA+WB-1:0] p
);

    logic [WA+WB-1:0] pipe [LATENCY];

    always_ff @(posedge clk) begin
        pipe[0] <= (WA+WB)'(a) * (WA+WB)'(b);
        for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end

    assign p = pipe[LATENCY-1];

endmodule

// File: rtl/multiplier_arbiter.sv
// multiplier_arbiter: round-robin sharing of one pipelined multiplier among NUM_REQ requesters
module multiplier_arbiter
    import multiplier_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH_1 = DEF_DATA_WIDTH_1,
    parameter int DATA_WIDTH_2 = DEF_DATA_WIDTH_2,
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int MULT_LATENCY = DEF_MULT_LATENCY
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid_i,
    output logic [NUM_REQ-1:0]               req_ready_o,
    input  logic [NUM_REQ*DATA_WIDTH_1-1:0]  req_data1_i,
    input  logic [NUM_REQ*DATA_WIDTH_2-1:0]  req_data2_i,
    output logic [NUM_REQ-1:0]               res_valid_o,
    output logic [DATA_WIDTH_1+DATA_WIDTH_2-1:0] res_data_o
);

    localparam int TAG_WIDTH = tag_width(NUM_REQ);
    localparam int PW        = DATA_WIDTH_1 + DATA_WIDTH_2;

    logic [TAG_WIDTH-1:0]    ptr, ptr_nxt, gidx;
    logic [NUM_REQ-1:0]      rot;
    logic                    found;
    logic [DATA_WIDTH_1-1:0] op1_d, op1_q;
    logic [DATA_WIDTH_2-1:0] op2_d, op2_q;
    logic [PW-1:0]           prod;
    logic [MULT_LATENCY:0]   vld;
    logic [TAG_WIDTH-1:0]    tag [MULT_LATENCY+1];

    // Rotating the request vector by the pointer makes bit 0 the highest priority
    assign rot = NUM_REQ'({req_valid_i, req_valid_i} >> ptr);

    always_comb begin
        found = 1'b0;
        gidx  = '0;
        for (int o = 0; o < NUM_REQ; o++) begin
            if (!found && rot[o]) begin
                found = 1'b1;
                gidx  = TAG_WIDTH'((int'(ptr) + o) % NUM_REQ);
            end
        end
    end

    always_comb begin
        op1_d = '0;
        op2_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gidx == TAG_WIDTH'(i)) begin
                op1_d = req_data1_i[i*DATA_WIDTH_1 +: DATA_WIDTH_1];
                op2_d = req_data2_i[i*DATA_WIDTH_2 +: DATA_WIDTH_2];
            end
        end
    end

    assign req_ready_o = (found && !rst) ? (NUM_REQ'(1) << gidx) : '0;
    assign ptr_nxt     = (gidx == TAG_WIDTH'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= '0;
            vld         <= '0;
            res_valid_o <= '0;
        end else begin
            if (found) ptr <= ptr_nxt;
            vld         <= {vld[MULT_LATENCY-1:0], found};
            res_valid_o <= vld[MULT_LATENCY] ? (NUM_REQ'(1) << tag[MULT_LATENCY]) : '0;
        end
    end

    // Datapath needs no reset: the valid pipeline alone qualifies it
    always_ff @(posedge clk) begin
        if (found) begin
            op1_q <= op1_d;
            op2_q <= op2_d;
        end
        tag[0] <= gidx;
        for (int i = 1; i <= MULT_LATENCY; i++) tag[i] <= tag[i-1];
        res_data_o <= prod;
    end

    multiplier_arbiter_mult #(
        .WA(DATA_WIDTH_1),
        .WB(DATA_WIDTH_2),
        .LATENCY(MULT_LATENCY)
    ) u_mult (
        .clk(clk),
        .a(op1_q),
        .b(op2_q),
        .p(prod)
    );

endmodule

// File: tb/tb_multiplier_arbiter.sv
// tb_multiplier_arbiter: directed and randomized checks against a queue-based arbitration model
module tb_multiplier_arbiter;

    localparam int N   = 4;
    localparam int LAT = 1;

    typedef struct { logic [7:0] a; logic [7:0] b; } op_t;
    typedef struct { int due; int tag; int p; } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    v = '0;
    logic [N-1:0]    req_ready_o, res_valid_o;
    logic [7:0]      a [N];
    logic [7:0]      b [N];
    logic [15:0]     res_data_o;

    op_t  q [N][$];
    exp_t pend[$];
    int   glog[$];
    int   rlog[$];
    int   checks = 0, failures = 0, cyc = 0, mptr = 0;

    multiplier_arbiter dut (
        .clk(clk),
        .rst(rst),
        .req_valid_i(v),
        .req_ready_o(req_ready_o),
        .req_data1_i({a[3], a[2], a[1], a[0]}),
        .req_data2_i({b[3], b[2], b[1], b[0]}),
        .res_valid_o(res_valid_o),
        .res_data_o(res_data_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic put(input int i, input int x, input int y);
        q[i].push_back('{8'(x), 8'(y)});
    endtask

    function automatic bit busy();
        bit r = pend.size() != 0;
        for (int i = 0; i < N; i++) if (q[i].size() != 0) r = 1'b1;
        return r;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            v[i] = q[i].size() != 0;
            a[i] = v[i] ? q[i][0].a : 8'h0;
            b[i] = v[i] ? q[i][0].b : 8'h0;
        end
    endtask

    // One clock: check grant before the edge, then the result strobe just after it
    task automatic tick();
        int k = -1;
        drive();
        #2;
        if (!rst)
            for (int o = 0; o < N; o++)
                if (k < 0 && v[(mptr + o) % N]) k = (mptr + o) % N;
        chk("ready", req_ready_o, (k >= 0) ? 32'(1 << k) : 32'd0);
        for (int i = 0; i < N; i++) if (req_ready_o[i]) glog.push_back(i);
        if (k >= 0)
            pend.push_back('{cyc + 1 + LAT + 1, k, int'(q[k][0].a) * int'(q[k][0].b)});
        @(posedge clk);
        cyc++;
        if (rst) begin
            pend.delete();
            mptr = 0;
        end else if (k >= 0) begin
            mptr = (k + 1) % N;
            void'(q[k].pop_front());
        end
        #1;
        if (pend.size() != 0 && pend[0].due == cyc) begin
            chk("res_valid", res_valid_o, 32'(1 << pend[0].tag));
            chk("res_data", res_data_o, pend[0].p);
            rlog.push_back(int'(res_data_o));
            void'(pend.pop_front());
        end else begin
            chk("res_idle", res_valid_o, 0);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (busy() && n < 200) begin
            tick();
            n++;
        end
        chk("drain_bound", busy(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();

        rlog.delete();
        put(0, 34, 22);
        drain();
        chk("r0_748", rlog.size() > 0 ? rlog[0] : -1, 748);

        rlog.delete();
        glog.delete();
        put(2, 34, 9);
        put(2, 9, 9);
        put(2, 99, 99);
        drain();
        chk("stream_0", rlog.size() > 0 ? rlog[0] : -1, 306);
        chk("stream_1", rlog.size() > 1 ? rlog[1] : -1, 81);
        chk("stream_2", rlog.size() > 2 ? rlog[2] : -1, 9801);
        chk("stream_grants", glog.size(), 3);

        do_reset();
        glog.delete();
        for (int i = 0; i < N; i++) put(i, i + 3, 2 * i + 1);
        drain();
        for (int i = 0; i < N; i++) chk("all4_order", glog.size() > i ? glog[i] : -1, i);

        do_reset();
        put(1, 5, 5);
        tick();
        glog.delete();
        for (int j = 0; j < 6; j++) begin
            put(1, j, 7);
            put(3, j, 11);
        end
        for (int j = 0; j < 4; j++) tick();
        chk("alt_0", glog.size() > 0 ? glog[0] : -1, 3);
        chk("alt_1", glog.size() > 1 ? glog[1] : -1, 1);
        chk("alt_2", glog.size() > 2 ? glog[2] : -1, 3);
        chk("alt_3", glog.size() > 3 ? glog[3] : -1, 1);
        put(0, 200, 3);
        glog.delete();
        tick();
        tick();
        chk("late0_grant", glog.size() > 1 ? glog[1] : -1, 0);
        drain();

        rlog.delete();
        put(0, 255, 255);
        tick();
        rst = 1'b1;
        tick();
        chk("rst_ready", req_ready_o, 0);
        chk("rst_res_valid", res_valid_o, 0);
        tick();
        rst = 1'b0;
        for (int j = 0; j < 3; j++) tick();
        chk("no_65025", rlog.size(), 0);

        put(2, 3, 4);
        drain();
        for (int j = 0; j < 10; j++) tick();
        glog.delete();
        for (int i = 0; i < N; i++) put(i, 1, i);
        tick();
        chk("ptr_hold", glog.size() > 0 ? glog[0] : -1, 3);
        drain();

        for (int j = 0; j < 400; j++) begin
            for (int i = 0; i < N; i++)
                if (q[i].size() == 0 && $urandom_range(0, 2) == 0)
                    put(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            rst = ($urandom_range(0, 59) == 0);
            tick();
        end
        rst = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
